rand_share_arbiter: RTL and testbench

//  Shares one 10-bit XNOR LFSR random source among NUM_REQ game requesters
//  (enemy spawn, target pick, etc.). Requesters compete under round-robin.
//  Per winner, the LFSR is stepped STEPS times to decorrelate successive draws.
//  The winner then gets one grant pulse carrying the fresh value.

---
 rtl/game_pkg.sv | 20 ++
 rtl/rsa_lfsr_core.sv | 46 ++++
 rtl/rand_share_arbiter.sv | 113 +++++++++++
 tb/tb_rand_share_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : game_pkg
//  Brief   : Shared types and constants for the random-share arbiter slice.
//  Revision: 1.0
// ============================================================================
package game_pkg;

  localparam int LFSR_WIDTH = 10;
  localparam int LFSR_TAP   = 3;
  localparam int STEP_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    ISSUE = 2'd2
  } rsa_state_t;

endpackage
`default_nettype wire

// File: rtl/rsa_lfsr_core.sv
`default_nettype none
// ============================================================================
//  Module  : rsa_lfsr_core
//  Brief   : XNOR LFSR with seed load, step enable and all-ones lock-up guard.
//  Revision: 1.0
// ============================================================================
module rsa_lfsr_core
  import game_pkg::*;
#(
  parameter int WIDTH = LFSR_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] next_o
);

  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_d;

  // Loading all-ones would lock the XNOR LFSR, so it is mapped to zero.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = (&load_val_i) ? '0 : load_val_i;
    end else if (&lfsr_q) begin
      lfsr_d = '0;
    end else if (step_i) begin
      lfsr_d = {~(lfsr_q[0] ^ lfsr_q[LFSR_TAP]), lfsr_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign next_o = lfsr_d;

endmodule
`default_nettype wire

// File: rtl/rand_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : rand_share_arbiter
//  Brief   : Round-robin sharing of one LFSR; each winner gets a fresh draw.
//  Revision: 1.0
// ============================================================================
module rand_share_arbiter
  import game_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = LFSR_WIDTH,
  parameter int STEPS   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               seed_load,
  input  logic [WIDTH-1:0]   seed_val,
  output logic [NUM_REQ-1:0] gnt,
  output logic               rand_valid,
  output logic [WIDTH-1:0]   rand_data,
  output logic               busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  rsa_state_t              state_q;
  logic [IDX_W-1:0]        winner_q;
  logic [IDX_W-1:0]        rr_ptr_q;
  logic [STEP_CNT_W-1:0]   step_cnt_q;
  logic [NUM_REQ-1:0]      gnt_q;
  logic                    rand_valid_q;
  logic [WIDTH-1:0]        rand_data_q;

  logic [IDX_W-1:0]        win_idx;
  logic                    win_found;
  int                      cand;
  logic [WIDTH-1:0]        lfsr_next;

  rsa_lfsr_core #(
    .WIDTH (WIDTH)
  ) u_lfsr (
    .clk        (clk),
    .reset      (reset),
    .step_i     (state_q == STEP),
    .load_i     (seed_load),
    .load_val_i (seed_val),
    .next_o     (lfsr_next)
  );

  // First requester at or after rr_ptr, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!win_found && req[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      winner_q     <= '0;
      rr_ptr_q     <= '0;
      step_cnt_q   <= '0;
      gnt_q        <= '0;
      rand_valid_q <= 1'b0;
      rand_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            winner_q   <= win_idx;
            step_cnt_q <= STEP_CNT_W'(STEPS - 1);
            state_q    <= STEP;
          end
        end
        STEP: begin
          if (step_cnt_q == '0) begin
            gnt_q        <= NUM_REQ'(1) << winner_q;
            rand_valid_q <= 1'b1;
            rand_data_q  <= lfsr_next;
            state_q      <= ISSUE;
          end else begin
            step_cnt_q <= step_cnt_q - STEP_CNT_W'(1);
          end
        end
        ISSUE: begin
          rr_ptr_q     <= (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + IDX_W'(1);
          gnt_q        <= '0;
          rand_valid_q <= 1'b0;
          rand_data_q  <= '0;
          state_q      <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign rand_valid = rand_valid_q;
  assign rand_data  = rand_data_q;
  assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rand_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_rand_share_arbiter
//  Brief   : Directed bench with a transaction-level model of rand_share_arbiter.
//  Revision: 1.0
// ============================================================================
module tb_rand_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 10;
  localparam int STEPS   = 3;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [NUM_REQ-1:0] req;
  logic               seed_load;
  logic [WIDTH-1:0]   seed_val;
  logic [NUM_REQ-1:0] gnt;
  logic               rand_valid;
  logic [WIDTH-1:0]   rand_data;
  logic               busy;

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;

  rand_share_arbiter #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH),
    .STEPS   (STEPS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .seed_load  (seed_load),
    .seed_val   (seed_val),
    .gnt        (gnt),
    .rand_valid (rand_valid),
    .rand_data  (rand_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int lfsr_step(input int v);
    int fb;
    if (v == 1023) return 0;
    fb = 1 - ((v ^ (v >> 3)) & 1);
    return ((v >> 1) | (fb << 9)) & 1023;
  endfunction

  // Transaction model: a request accepted at one edge is granted STEPS edges later,
  // and the arbiter is free again one edge after that.
  int               m_lfsr = 0;
  int               m_rr = 0;
  int               m_age = 0;
  int               m_win = 0;
  logic [NUM_REQ-1:0] e_gnt = '0;
  logic             e_valid = 1'b0;
  logic [WIDTH-1:0] e_data = '0;
  logic             e_busy = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_lfsr = 0; m_rr = 0; m_age = 0;
      e_gnt = '0; e_valid = 1'b0; e_data = '0;
    end else begin
      if (seed_load)                         m_lfsr = (seed_val == 10'h3FF) ? 0 : int'(seed_val);
      else if (m_lfsr == 1023)               m_lfsr = 0;
      else if (m_age >= 1 && m_age <= STEPS) m_lfsr = lfsr_step(m_lfsr);

      if (m_age == 0) begin
        if (req != '0) begin
          for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req[(m_rr + k) % NUM_REQ]) m_win = (m_rr + k) % NUM_REQ;
          m_age = 1;
        end
      end else if (m_age < STEPS) begin
        m_age++;
      end else if (m_age == STEPS) begin
        e_gnt = NUM_REQ'(1) << m_win; e_valid = 1'b1; e_data = WIDTH'(m_lfsr);
        m_age++;
      end else begin
        m_rr = (m_win + 1) % NUM_REQ;
        e_gnt = '0; e_valid = 1'b0; e_data = '0;
        m_age = 0;
      end
    end
    e_busy = (m_age != 0);
    #1;
    chk("cmp_gnt", 32'(gnt), 32'(e_gnt));
    chk("cmp_valid", 32'(rand_valid), 32'(e_valid));
    chk("cmp_data", 32'(rand_data), 32'(e_data));
    chk("cmp_busy", 32'(busy), 32'(e_busy));
  end

  task automatic wait_gnt(output logic [NUM_REQ-1:0] g, output logic [WIDTH-1:0] d, output int c);
    bit seen;
    seen = 1'b0; g = '0; d = '0; c = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (rand_valid) begin
        seen = 1'b1; g = gnt; d = rand_data; c = cyc;
      end
    end
    if (!seen) begin
      n_tot++;
      $display("FAIL grant_timeout: got no grant, required one within 20 cycles");
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; req = '0;
    @(negedge clk);
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    logic [NUM_REQ-1:0] g;
    logic [WIDTH-1:0]   d;
    int                 c, prev;
    req = '0; seed_load = 1'b0; seed_val = '0;
    prev = 0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_data", 32'(rand_data), 0);
    reset = 1'b0;

    // Single requester, two consecutive draws from the zero state.
    @(negedge clk); req = 4'b0001;
    wait_gnt(g, d, c); chk("t1_gnt0", 32'(g), 32'h1); chk("t1_data0", 32'(d), 32'h380);
    wait_gnt(g, d, c); chk("t1_gnt1", 32'(g), 32'h1); chk("t1_data1", 32'(d), 32'h3F0);
    req = '0;

    // All requesting: rotation and spacing.
    do_reset(); req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_gnt(g, d, c);
      chk("t2_gnt", 32'(g), 32'(1 << (i % 4)));
      if (i > 0) chk("t2_spacing", 32'(c - prev), STEPS + 2);
      prev = c;
    end
    req = 4'b1000;

    // Wrap to the top requester, then pointer returns to 0.
    wait_gnt(g, d, c); chk("t3_wrap", 32'(g), 32'h8);
    req = 4'b1001;
    wait_gnt(g, d, c); chk("t3_after_wrap", 32'(g), 32'h1);
    req = '0;

    // Seed handling.
    @(negedge clk); seed_load = 1'b1; seed_val = 10'h3FF;
    @(negedge clk); seed_load = 1'b0;
    chk("t4_lockup_seed", 32'(dut.u_lfsr.lfsr_q), 0);
    req = 4'b0001;
    @(negedge clk); seed_load = 1'b1; seed_val = 10'h155;
    @(negedge clk); seed_load = 1'b0;
    wait_gnt(g, d, c); chk("t4_gnt", 32'(g), 32'h1); chk("t4_seed_data", 32'(d), 32'h055);
    req = '0;

    // Winner withdraws mid-transaction.
    @(negedge clk); req = 4'b1010;
    @(negedge clk);
    @(negedge clk); req = 4'b1000;
    wait_gnt(g, d, c); chk("t5_dropped_gnt", 32'(g), 32'h2);
    wait_gnt(g, d, c); chk("t5_next_rr", 32'(g), 32'h8);
    req = '0;

    // Reset during STEP.
    @(negedge clk); req = 4'b0001;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    #1;
    chk("t6s_gnt", 32'(gnt), 0); chk("t6s_valid", 32'(rand_valid), 0);
    chk("t6s_busy", 32'(busy), 0); chk("t6s_lfsr", 32'(dut.u_lfsr.lfsr_q), 0);
    req = '0;
    @(negedge clk); reset = 1'b0;

    // Reset during ISSUE, then a fresh draw from zero.
    @(negedge clk); req = 4'b0001;
    wait_gnt(g, d, c); chk("t6i_pre_gnt", 32'(g), 32'h1);
    reset = 1'b1;
    #1;
    chk("t6i_gnt", 32'(gnt), 0); chk("t6i_valid", 32'(rand_valid), 0);
    chk("t6i_data", 32'(rand_data), 0); chk("t6i_busy", 32'(busy), 0);
    chk("t6i_lfsr", 32'(dut.u_lfsr.lfsr_q), 0);
    @(negedge clk); reset = 1'b0;
    wait_gnt(g, d, c); chk("t6_post_data", 32'(d), 32'h380);
    req = '0;

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
